// File: rtl/midi_stream_merger.sv
// midi_stream_merger: merges NUM_SRC MIDI byte streams into one, never interleaving messages.
// Define MIDI_MERGE_RUNNING_STATUS_EN to re-insert stored running status before orphan data bytes.
module midi_stream_merger #(
    parameter int NUM_SRC = 2,
    parameter int FIFO_DEPTH = 16,
    localparam int SRC_W = NUM_SRC > 2 ? $clog2(NUM_SRC) : 1
) (
    input  logic                 data_clk,
    input  logic                 reset_n,
    input  logic [NUM_SRC-1:0]   src_valid,
    input  logic [8*NUM_SRC-1:0] src_data,
    output logic [NUM_SRC-1:0]   src_ready,
    output logic                 out_valid,
    output logic [7:0]           out_data,
    output logic [SRC_W-1:0]     out_src,
    output logic                 out_sop,
    input  logic                 out_ready,
    output logic [NUM_SRC-1:0]   overflow,
    input  logic                 clr_ovf,
    output logic                 drop,
    output logic                 busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, MSG, SYSEX} state_t;

    state_t state, state_nx;
    logic [7:0] mem [NUM_SRC][FIFO_DEPTH];
    logic [AW-1:0] wr_ptr [NUM_SRC];
    logic [AW-1:0] rd_ptr [NUM_SRC];
    logic [CW-1:0] cnt [NUM_SRC];
    logic [CW-1:0] cnt_nx [NUM_SRC];
    logic [NUM_SRC-1:0] wr, rd, fifo_ne;
    logic [SRC_W-1:0] grant, grant_nx, ptr, ptr_nx, rr_sel, sel, sel_inc;
    logic rr_hit, avail, out_free, emit, pop_now, drop_now, emit_sop;
    logic [7:0] head, emit_data;
    logic [1:0] rem, rem_nx;
    int j;
`ifdef MIDI_MERGE_RUNNING_STATUS_EN
    logic [7:0] rs_byte [NUM_SRC];
    logic [NUM_SRC-1:0] rs_valid;
    logic rs_set, rs_clr;
`endif

    function automatic logic [1:0] ndata(input logic [7:0] b);
        return (b[7:4] == 4'hC || b[7:4] == 4'hD || b == 8'hF1 || b == 8'hF3) ? 2'd1 :
               (b[7:4] != 4'hF || b == 8'hF2) ? 2'd2 : 2'd0;
    endfunction

    assign busy     = state != IDLE;
    assign sel      = (state == IDLE) ? rr_sel : grant;
    assign avail    = (state == IDLE) ? rr_hit : fifo_ne[grant];
    assign sel_inc  = (sel == SRC_W'(NUM_SRC - 1)) ? '0 : sel + 1'b1;
    assign head     = mem[sel][rd_ptr[sel]];
    assign out_free = !out_valid || out_ready;

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) fifo_ne[i] = cnt[i] != '0;
    end

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            wr[i] = src_valid[i] && src_ready[i];
            rd[i] = (pop_now || drop_now) && sel == SRC_W'(i);
            cnt_nx[i] = cnt[i] + CW'(wr[i]) - CW'(rd[i]);
        end
    end

    // descending scan so the source right at ptr has the highest priority
    always_comb begin
        rr_sel = ptr;
        rr_hit = 1'b0;
        j = 0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % NUM_SRC;
            if (fifo_ne[SRC_W'(j)]) begin
                rr_hit = 1'b1;
                rr_sel = SRC_W'(j);
            end
        end
    end

    always_comb begin
        state_nx = state;
        rem_nx = rem;
        grant_nx = grant;
        ptr_nx = ptr;
        emit = 1'b0;
        pop_now = 1'b0;
        drop_now = 1'b0;
        emit_data = head;
        emit_sop = 1'b0;
`ifdef MIDI_MERGE_RUNNING_STATUS_EN
        rs_set = 1'b0;
        rs_clr = 1'b0;
`endif
        if (avail && state == IDLE && !head[7]) begin
`ifdef MIDI_MERGE_RUNNING_STATUS_EN
            if (rs_valid[sel]) begin
                if (out_free) begin
                    emit = 1'b1;
                    emit_data = rs_byte[sel];
                    emit_sop = 1'b1;
                    state_nx = MSG;
                    rem_nx = ndata(rs_byte[sel]);
                    grant_nx = sel;
                    ptr_nx = sel_inc;
                end
            end else begin
                drop_now = 1'b1;
                ptr_nx = sel_inc;
            end
`else
            drop_now = 1'b1;
            ptr_nx = sel_inc;
`endif
        end else if (avail && out_free) begin
            emit = 1'b1;
            pop_now = 1'b1;
            grant_nx = sel;
            ptr_nx = sel_inc;
            if (head >= 8'hF8) emit_sop = 1'b1;
            else if (state == SYSEX && head == 8'hF7) state_nx = IDLE;
            else if (head[7]) begin
                emit_sop = 1'b1;
                state_nx = (head == 8'hF0) ? SYSEX : (ndata(head) == 2'd0) ? IDLE : MSG;
                rem_nx = ndata(head);
`ifdef MIDI_MERGE_RUNNING_STATUS_EN
                rs_set = head < 8'hF0;
                rs_clr = head >= 8'hF0;
`endif
            end else if (state == MSG) begin
                rem_nx = rem - 2'd1;
                state_nx = (rem == 2'd1) ? IDLE : MSG;
            end
        end
    end

    always_ff @(posedge data_clk) begin
        for (int i = 0; i < NUM_SRC; i++)
            if (wr[i]) mem[i][wr_ptr[i]] <= src_data[8*i +: 8];
    end

    always_ff @(posedge data_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            rem <= '0;
            grant <= '0;
            ptr <= '0;
            src_ready <= '0;
            overflow <= '0;
            out_valid <= 1'b0;
            out_data <= '0;
            out_src <= '0;
            out_sop <= 1'b0;
            drop <= 1'b0;
            for (int i = 0; i < NUM_SRC; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                cnt[i] <= '0;
            end
        end else begin
            state <= state_nx;
            rem <= rem_nx;
            grant <= grant_nx;
            ptr <= ptr_nx;
            overflow <= (src_valid & ~src_ready) | (overflow & {NUM_SRC{!clr_ovf}});
            drop <= drop_now;
            if (out_free) out_valid <= emit;
            if (emit) begin
                out_data <= emit_data;
                out_src <= sel;
                out_sop <= emit_sop;
            end
            for (int i = 0; i < NUM_SRC; i++) begin
                if (wr[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (rd[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
                cnt[i] <= cnt_nx[i];
                src_ready[i] <= cnt_nx[i] != CW'(FIFO_DEPTH);
            end
        end
    end

`ifdef MIDI_MERGE_RUNNING_STATUS_EN
    always_ff @(posedge data_clk or negedge reset_n) begin
        if (!reset_n) begin
            rs_valid <= '0;
            for (int i = 0; i < NUM_SRC; i++) rs_byte[i] <= '0;
        end else if (rs_set) begin
            rs_byte[sel] <= head;
            rs_valid[sel] <= 1'b1;
        end else if (rs_clr) rs_valid[sel] <= 1'b0;
    end
`endif
endmodule

// File: tb/tb_midi_stream_merger.sv
// tb_midi_stream_merger: table-driven message vectors plus hand-written overflow, latency and reset sequences.
module tb_midi_stream_merger;
    localparam int NS = 2;
    localparam int FD = 16;
`ifdef MIDI_MERGE_RUNNING_STATUS_EN
    localparam int DROP3 = 0;
`else
    localparam int DROP3 = 2;
`endif

    typedef struct packed { logic [3:0] grp; logic src; logic [7:0] b; } stim_t;
    typedef struct packed { logic [3:0] grp; logic [7:0] d; logic s; logic sop; } exp_t;
    typedef struct packed { logic [7:0] d; logic s; logic sop; logic bsy; } obs_t;

    logic data_clk = 1'b0;
    logic reset_n;
    logic [NS-1:0] src_valid, src_ready, overflow;
    logic [8*NS-1:0] src_data;
    logic out_valid, out_sop, out_ready, clr_ovf, drop, busy, out_src;
    logic [7:0] out_data;

    stim_t stim [$];
    exp_t expv [$];
    obs_t got [$];
    logic [7:0] sq [NS][$];
    int checks = 0;
    int errors = 0;
    int drops = 0;

    midi_stream_merger #(.NUM_SRC(NS), .FIFO_DEPTH(FD)) dut (
        .data_clk(data_clk), .reset_n(reset_n),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src), .out_sop(out_sop),
        .out_ready(out_ready), .overflow(overflow), .clr_ovf(clr_ovf), .drop(drop), .busy(busy)
    );

    always #5 data_clk = ~data_clk;

    always @(negedge data_clk) begin
        if (reset_n && out_valid && out_ready) got.push_back({out_data, out_src, out_sop, busy});
        if (reset_n && drop) drops++;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void add_stim(input int g, input logic s, input int n, input logic [47:0] b);
        for (int i = 0; i < n; i++) stim.push_back({4'(g), s, b[8*(n-1-i) +: 8]});
    endfunction

    function automatic void add_exp(input int g, input logic s, input int n, input logic [47:0] b,
                                    input logic [5:0] sop);
        for (int i = 0; i < n; i++) expv.push_back({4'(g), b[8*(n-1-i) +: 8], s, sop[n-1-i]});
    endfunction

    task automatic drive_all();
        for (int t = 0; t < 200 && (sq[0].size() > 0 || sq[1].size() > 0); t++) begin
            @(posedge data_clk); #1;
            for (int s = 0; s < NS; s++) begin
                src_valid[s] = sq[s].size() > 0;
                if (sq[s].size() > 0) begin
                    src_data[8*s +: 8] = sq[s][0];
                    if (src_ready[s]) void'(sq[s].pop_front());
                end
            end
        end
        @(posedge data_clk); #1;
        src_valid = '0;
        for (int s = 0; s < NS; s++) sq[s].delete();
    endtask

    task automatic wait_out(input int base, input int n);
        for (int t = 0; t < 300 && got.size() < base + n; t++) @(negedge data_clk);
        repeat (6) @(negedge data_clk);
    endtask

    task automatic run_group(input int g, input int ndrop, output int gb);
        int n = 0;
        int k = 0;
        int db;
        gb = got.size();
        db = drops;
        foreach (stim[i]) if (int'(stim[i].grp) == g) sq[stim[i].src].push_back(stim[i].b);
        foreach (expv[i]) if (int'(expv[i].grp) == g) n++;
        drive_all();
        wait_out(gb, n);
        chk($sformatf("g%0d count", g), got.size() - gb, n);
        foreach (expv[i]) if (int'(expv[i].grp) == g) begin
            if (gb + k < got.size())
                chk($sformatf("g%0d byte%0d", g, k), {got[gb+k].d, got[gb+k].s, got[gb+k].sop},
                    {expv[i].d, expv[i].s, expv[i].sop});
            k++;
        end
        chk($sformatf("g%0d drops", g), drops - db, ndrop);
    endtask

    initial begin
        int acc;
        int gb;
        int db;
        reset_n = 1'b0;
        src_valid = '0;
        src_data = '0;
        out_ready = 1'b0;
        clr_ovf = 1'b0;
        add_stim(1, 0, 3, 48'h903C64);     add_exp(1, 0, 3, 48'h903C64, 6'b100);
        add_stim(1, 1, 3, 48'h804000);     add_exp(1, 1, 3, 48'h804000, 6'b100);
        add_stim(2, 0, 4, 48'hF07E01F7);   add_exp(2, 0, 4, 48'hF07E01F7, 6'b1000);
        add_stim(2, 1, 2, 48'hC510);       add_exp(2, 1, 2, 48'hC510, 6'b10);
        add_stim(3, 0, 5, 48'h903C643E50);
`ifdef MIDI_MERGE_RUNNING_STATUS_EN
        add_exp(3, 0, 6, 48'h903C64903E50, 6'b100100);
`else
        add_exp(3, 0, 3, 48'h903C64, 6'b100);
`endif
        add_stim(4, 1, 4, 48'hB007F87F);   add_exp(4, 1, 4, 48'hB007F87F, 6'b1010);
        add_stim(5, 0, 4, 48'h903CC305);   add_exp(5, 0, 4, 48'h903CC305, 6'b1010);
        add_stim(6, 1, 2, 48'hF8F6);       add_exp(6, 1, 2, 48'hF8F6, 6'b11);

        #2;
        chk("reset outputs", {out_valid, out_sop, out_src, drop, busy, src_ready, overflow, out_data}, '0);
        repeat (2) @(posedge data_clk);
        #1 reset_n = 1'b1;
        @(posedge data_clk); #1;
        chk("ready after reset", src_ready, 2'b11);
        out_ready = 1'b1;

        for (int g = 1; g <= 6; g++) begin
            run_group(g, (g == 3) ? DROP3 : 0, gb);
            if (g == 2 && got.size() >= gb + 4)
                chk("g2 sysex busy", {got[gb].bsy, got[gb+1].bsy, got[gb+2].bsy, got[gb+3].bsy}, 4'b1110);
            if (g == 4 && got.size() >= gb + 3) chk("g4 realtime busy", got[gb+2].bsy, 1'b1);
            if (g == 4) chk("g4 busy end", busy, 1'b0);
        end

        @(posedge data_clk); #1;
        src_valid = 2'b10;
        src_data[15:8] = 8'hFA;
        @(posedge data_clk); #1;
        src_valid = '0;
        chk("latency N+1 valid", out_valid, 1'b0);
        @(posedge data_clk); #1;
        chk("latency N+2", {out_valid, out_data, out_src, out_sop}, {1'b1, 8'hFA, 1'b1, 1'b1});
        repeat (4) @(posedge data_clk);

        #1 out_ready = 1'b0;
        acc = 0;
        for (int t = 0; t < FD + 4; t++) begin
            @(posedge data_clk); #1;
            src_valid = 2'b01;
            src_data[7:0] = 8'hF8 + 8'(acc % 8);
            if (src_ready[0]) acc++;
        end
        @(posedge data_clk); #1;
        src_valid = '0;
        chk("fill accepted", acc, FD + 1);
        chk("full ready", src_ready, 2'b10);
        chk("overflow set", overflow, 2'b01);
        chk("stall hold", {out_valid, out_data, out_src, out_sop}, {1'b1, 8'hF8, 1'b0, 1'b1});
        clr_ovf = 1'b1;
        src_valid = 2'b01;
        @(posedge data_clk); #1;
        clr_ovf = 1'b0;
        src_valid = '0;
        chk("overflow clr vs new", overflow, 2'b01);
        @(posedge data_clk); #1;
        chk("overflow sticky", overflow, 2'b01);
        clr_ovf = 1'b1;
        @(posedge data_clk); #1;
        clr_ovf = 1'b0;
        chk("overflow cleared", overflow, 2'b00);
        gb = got.size();
        out_ready = 1'b1;
        wait_out(gb, FD + 1);
        chk("drain count", got.size() - gb, FD + 1);
        for (int k = 0; k < FD + 1; k++)
            if (gb + k < got.size())
                chk($sformatf("drain byte%0d", k), {got[gb+k].d, got[gb+k].s, got[gb+k].sop},
                    {8'hF8 + 8'(k % 8), 1'b0, 1'b1});
        chk("drain ready", src_ready, 2'b11);

        out_ready = 1'b0;
        sq[0].push_back(8'h90);
        sq[0].push_back(8'h3C);
        sq[0].push_back(8'h64);
        drive_all();
        repeat (2) @(posedge data_clk); #1;
        chk("pre-reset busy", {busy, out_valid, out_data}, {1'b1, 1'b1, 8'h90});
        reset_n = 1'b0;
        #1;
        chk("async reset", {out_valid, busy, src_ready, out_data}, '0);
        @(posedge data_clk); #1;
        reset_n = 1'b1;
        out_ready = 1'b1;
        gb = got.size();
        db = drops;
        repeat (6) @(posedge data_clk); #1;
        chk("post-reset idle", {out_valid, src_ready}, {1'b0, 2'b11});
        chk("post-reset empty", {got.size() - gb, drops - db}, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
